// File: rtl/dsm_pkg.sv
// Shared delta-sigma constants: PCM format (two's complement, bit 15 = 1.0 V)
// and the sinc^3 decimator sizing helpers.
package dsm_pkg;

  localparam int PCM_W = 20;

  localparam logic signed [PCM_W-1:0] VIN_FS          = 20'sh0_8000;
  localparam logic signed [PCM_W-1:0] VIN_FS_HALF     = 20'sh0_4000;
  localparam logic signed [PCM_W-1:0] VIN_FS_HALF_NEG = 20'shF_C000;

  // Integrator width: 3*log2(R) bits of growth on a +/-1 input plus sign headroom.
  function automatic int cic_width(input int dec_log2);
    return 32'sd3 * dec_log2 + 32'sd2;
  endfunction

  // Right shift that maps the R^3 full-scale gain onto bit 15.
  function automatic int cic_shift(input int dec_log2);
    return 32'sd3 * dec_log2 - 32'sd15;
  endfunction

endpackage

// File: rtl/dsm_comb.sv
// Registered differentiator y = x - x_prev, one CIC comb stage.
module dsm_comb
  import dsm_pkg::*;
#(
  parameter int W = PCM_W
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_en,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  logic [W-1:0] r_prev;
  logic [W-1:0] r_y;

  // Difference against the previous enabled input; state holds when idle
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prev <= '0;
      r_y    <= '0;
    end else if (i_en) begin
      r_prev <= i_x;
      r_y    <= i_x - r_prev;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/dsm_decimator.sv
// Third-order CIC decimator: 1-bit modulator stream in, 20-bit PCM out
// through a one-entry valid/ready output register with sticky overrun.
module dsm_decimator
  import dsm_pkg::*;
#(
  parameter int DEC_LOG2 = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pwm,
  output logic [PCM_W-1:0] pcm_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int W     = cic_width(DEC_LOG2);
  localparam int S     = cic_shift(DEC_LOG2);
  localparam int EXT_W = (W > PCM_W) ? W : PCM_W;

  logic                    r_pwm;
  logic signed [W-1:0]     r_int1;
  logic signed [W-1:0]     r_int2;
  logic signed [W-1:0]     r_int3;
  logic signed [W-1:0]     w_x;
  logic signed [W-1:0]     w_int1_nxt;
  logic signed [W-1:0]     w_int2_nxt;
  logic signed [W-1:0]     w_int3_nxt;
  logic [DEC_LOG2-1:0]     r_phase;
  logic                    w_strobe;
  logic                    r_str_d1;
  logic                    r_str_d2;
  logic                    r_str_d3;
  logic [1:0]              r_warm;
  logic [W-1:0]            w_y1;
  logic [W-1:0]            w_y2;
  logic [W-1:0]            w_y3;
  logic signed [W-1:0]     w_scaled;
  logic signed [EXT_W-1:0] w_ext;
  logic [PCM_W-1:0]        w_sample;
  logic                    w_new;
  logic [PCM_W-1:0]        r_pcm;
  logic                    r_valid;
  logic                    r_overrun;

  // +1 for a one bit, -1 (all ones) for a zero bit
  assign w_x = {{(W-1){~r_pwm}}, 1'b1};

  // The integrators chain on next-state values so the third strobe after
  // reset sees exactly the last 3R-2 inputs and is fully settled.
  assign w_int1_nxt = r_int1 + w_x;
  assign w_int2_nxt = r_int2 + w_int1_nxt;
  assign w_int3_nxt = r_int3 + w_int2_nxt;

  assign w_strobe = (r_phase == {DEC_LOG2{1'b1}});

  // Input register, wrapping integrators and phase counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pwm   <= 1'b0;
      r_int1  <= '0;
      r_int2  <= '0;
      r_int3  <= '0;
      r_phase <= '0;
    end else begin
      r_pwm   <= pwm;
      r_int1  <= w_int1_nxt;
      r_int2  <= w_int2_nxt;
      r_int3  <= w_int3_nxt;
      r_phase <= r_phase + {{(DEC_LOG2-1){1'b0}}, 1'b1};
    end
  end

  // Strobe delay line steps one comb stage per cycle; warm-up counts discarded samples
  always_ff @(posedge clock) begin
    if (reset) begin
      r_str_d1 <= 1'b0;
      r_str_d2 <= 1'b0;
      r_str_d3 <= 1'b0;
      r_warm   <= 2'd0;
    end else begin
      r_str_d1 <= w_strobe;
      r_str_d2 <= r_str_d1;
      r_str_d3 <= r_str_d2;
      if (r_str_d3 && (r_warm != 2'd2)) begin
        r_warm <= r_warm + 2'd1;
      end
    end
  end

  dsm_comb #(.W(W)) u_comb1 (
    .i_clock (clock),
    .i_reset (reset),
    .i_en    (w_strobe),
    .i_x     (r_int3),
    .o_y     (w_y1)
  );

  dsm_comb #(.W(W)) u_comb2 (
    .i_clock (clock),
    .i_reset (reset),
    .i_en    (r_str_d1),
    .i_x     (w_y1),
    .o_y     (w_y2)
  );

  dsm_comb #(.W(W)) u_comb3 (
    .i_clock (clock),
    .i_reset (reset),
    .i_en    (r_str_d2),
    .i_x     (w_y2),
    .o_y     (w_y3)
  );

  // Floor scaling, then sign-extend or truncate into the PCM width
  assign w_scaled = $signed(w_y3) >>> S;
  assign w_ext    = EXT_W'(w_scaled);
  assign w_sample = w_ext[PCM_W-1:0];
  assign w_new    = r_str_d3 && (r_warm == 2'd2);

  // One-entry output register: newest sample wins, overwrite is flagged
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pcm     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_new) begin
      r_pcm   <= w_sample;
      r_valid <= 1'b1;
      if (r_valid && !out_ready) begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign pcm_out   = r_pcm;
  assign out_valid = r_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_dsm_decimator.sv
// Bench for dsm_decimator: a direct-form sinc^3 convolution of the driven
// bitstream feeds a scoreboard queue that is checked at every handshake.
`timescale 1ns/1ps
module tb_dsm_decimator;
  import dsm_pkg::*;

  localparam int DEC_LOG2 = 6;
  localparam int R        = 1 << DEC_LOG2;
  localparam int NTAP     = 3 * R - 2;
  localparam int S        = cic_shift(DEC_LOG2);
  localparam int HIST     = 4096;
  localparam int FIRST_VALID_EDGE = 3 * R - 1 + 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        pwm;
  logic        out_ready;
  logic [19:0] pcm_out;
  logic        out_valid;
  logic        overrun;

  dsm_decimator #(.DEC_LOG2(DEC_LOG2)) dut (
    .clock     (clock),
    .reset     (reset),
    .pwm       (pwm),
    .pcm_out   (pcm_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          h[NTAP];
  bit          hist[HIST];
  int          e;
  logic [19:0] exp_q[$];

  // Output sample for strobe edge k: taps over pwm driven before edges k-2 .. k-3R+1.
  function automatic logic [19:0] model_at(input int k);
    int y;
    y = 0;
    for (int j = 0; j < NTAP; j++) y += h[j] * (hist[k - 2 - j] ? 1 : -1);
    y = y >>> S;
    return y[19:0];
  endfunction

  function automatic bit pat_bit(input int kind, input int idx);
    case (kind)
      0:       return 1'b1;
      1:       return 1'b0;
      2:       return (idx % 2) == 0;
      3:       return (idx % 4) != 3;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Called at a negedge: drive pwm for edge e, push expected sample, report handshake.
  task automatic step_cycle(input bit p, output bit hs, output logic [19:0] v);
    pwm = p;
    if (e < HIST) hist[e] = p;
    if (((e % R) == R - 1) && (e >= 3 * R - 1) && (e < HIST)) exp_q.push_back(model_at(e));
    hs = out_valid && out_ready;
    v  = pcm_out;
    @(posedge clock);
    e++;
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    pwm   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    e = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    apply_reset();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    n_checks++;
    if (pcm_out !== 20'h0_0000) begin n_fail++; $display("FAIL reset_pcm got %h want 00000", pcm_out); end
  endtask

  task automatic test_const_high();
    bit hs;
    logic [19:0] v, ex;
    int got, first;
    got = 0;
    first = -1;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8 * R; i++) begin
      step_cycle(1'b1, hs, v);
      if (out_valid === 1'b1 && first < 0) first = e - 1;
      if (hs) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL const_high_extra got %h want no sample", v);
        end else begin
          ex = exp_q.pop_front();
          if (v !== ex) begin n_fail++; $display("FAIL const_high_model got %h want %h", v, ex); end
          n_checks++;
          if (v !== VIN_FS) begin n_fail++; $display("FAIL const_high_value got %h want %h", v, VIN_FS); end
        end
      end
    end
    n_checks++;
    if (first !== FIRST_VALID_EDGE) begin n_fail++; $display("FAIL const_high_first_edge got %0d want %0d", first, FIRST_VALID_EDGE); end
    n_checks++;
    if (got !== 5) begin n_fail++; $display("FAIL const_high_count got %0d want 5", got); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL const_high_overrun got %b want 0", overrun); end
  endtask

  task automatic test_pattern(input string name, input int kind, input bit use_spec, input logic [19:0] spec_val);
    bit hs;
    logic [19:0] v, ex;
    int got;
    got = 0;
    out_ready = 1'b1;
    apply_reset();
    for (int i = 0; i < 8 * R; i++) begin
      step_cycle(pat_bit(kind, e), hs, v);
      if (hs) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s_extra got %h want no sample", name, v);
        end else begin
          ex = exp_q.pop_front();
          if (v !== ex) begin n_fail++; $display("FAIL %s_model got %h want %h", name, v, ex); end
          if (use_spec) begin
            n_checks++;
            if (v !== spec_val) begin n_fail++; $display("FAIL %s_value got %h want %h", name, v, spec_val); end
          end
        end
      end
    end
    n_checks++;
    if (got !== 5) begin n_fail++; $display("FAIL %s_count got %0d want 5", name, got); end
  endtask

  task automatic test_backpressure();
    bit hs;
    logic [19:0] v, ex;
    int k, hs_after;
    out_ready = 1'b0;
    apply_reset();
    while (e < 330) begin
      step_cycle(1'b1, hs, v);
      k = e - 1;
      if (k >= FIRST_VALID_EDGE) begin
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held edge %0d got %b want 1", k, out_valid); end
      end
      n_checks++;
      if (overrun !== (k >= 4 * R + 2)) begin
        n_fail++; $display("FAIL bp_overrun edge %0d got %b want %b", k, overrun, (k >= 4 * R + 2));
      end
    end
    out_ready = 1'b1;
    step_cycle(1'b1, hs, v);
    n_checks++;
    if (hs !== 1'b1) begin n_fail++; $display("FAIL bp_consume got hs=%b want 1", hs); end
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    ex = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hX_XXXX;
    n_checks++;
    if (v !== ex) begin n_fail++; $display("FAIL bp_sample_model got %h want %h", v, ex); end
    n_checks++;
    if (v !== VIN_FS) begin n_fail++; $display("FAIL bp_sample_value got %h want %h", v, VIN_FS); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", out_valid); end
    hs_after = 0;
    while (e < 380) begin
      step_cycle(1'b1, hs, v);
      if (hs) hs_after++;
    end
    n_checks++;
    if (hs_after !== 0) begin n_fail++; $display("FAIL bp_one_only got %0d extra want 0", hs_after); end
    n_checks++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", overrun); end
  endtask

  // Continues the backpressure stream; reset lands while a sample is in the comb pipeline.
  task automatic test_reset_midstream();
    bit hs;
    logic [19:0] v, ex;
    int first, got;
    out_ready = 1'b1;
    while (e < 6 * R + 1) step_cycle(1'b1, hs, v);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b want 0", out_valid); end
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_reset_overrun got %b want 0", overrun); end
    n_checks++;
    if (pcm_out !== 20'h0_0000) begin n_fail++; $display("FAIL mid_reset_pcm got %h want 00000", pcm_out); end
    reset = 1'b0;
    e = 0;
    exp_q.delete();
    first = -1;
    got = 0;
    while (e < 4 * R) begin
      step_cycle(1'b1, hs, v);
      if (out_valid === 1'b1 && first < 0) first = e - 1;
      if (hs) begin
        got++;
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hX_XXXX;
        n_checks++;
        if (v !== ex) begin n_fail++; $display("FAIL mid_sample_model got %h want %h", v, ex); end
        n_checks++;
        if (v !== VIN_FS) begin n_fail++; $display("FAIL mid_sample_value got %h want %h", v, VIN_FS); end
      end
    end
    n_checks++;
    if (first !== FIRST_VALID_EDGE) begin n_fail++; $display("FAIL mid_first_edge got %0d want %0d", first, FIRST_VALID_EDGE); end
    n_checks++;
    if (got !== 1) begin n_fail++; $display("FAIL mid_count got %0d want 1", got); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    pwm       = 1'b0;
    out_ready = 1'b0;
    e         = 0;
    for (int j = 0; j < NTAP; j++) h[j] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++)
          h[a + b + c] += 1;
    @(negedge clock);
    test_reset();
    test_const_high();
    test_pattern("const_low", 1, 1'b1, -VIN_FS);
    test_pattern("alternating", 2, 1'b1, 20'h0_0000);
    test_pattern("density75", 3, 1'b1, VIN_FS_HALF);
    test_pattern("random", 4, 1'b0, 20'h0_0000);
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
